// File: rtl/ifu_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ifu_fetch : instruction fetch unit with a 2-deep output FIFO, credit-based  |
// |             request throttling and redirect flush / stale-response discard. |
// | Optional   : define IFU_PERF_CNT_EN to add the fetch_cnt handshake counter. |
// | Revision   : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
`ifndef PC_SIZE
`define PC_SIZE 32
`endif
module ifu_fetch #(
  parameter int PC_W = `PC_SIZE,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PC_W-1:0]    pc_rtvec,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PC_W-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               imem_rsp_err,
  output logic               ifu_valid,
  input  logic               ifu_ready,
  output logic [INSTR_W-1:0] ifu_instr,
  output logic [PC_W-1:0]    ifu_pc,
  output logic               ifu_err,
`ifdef IFU_PERF_CNT_EN
  output logic [31:0]        fetch_cnt,
`endif
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc
);

  typedef enum logic [0:0] {BOOT = 1'b0, RUN = 1'b1} state_e;

  state_e             state_q;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [1:0]         disc_q, disc_d;

  logic [INSTR_W-1:0] fifo_instr_q [2];
  logic [PC_W-1:0]    fifo_pc_q    [2];
  logic [1:0]         fifo_err_q;
  logic               fifo_rd_q, fifo_wr_q;
  logic [1:0]         fifo_cnt_q;

  logic [PC_W-1:0]    infl_pc_q [2];
  logic               infl_rd_q, infl_wr_q;
  logic [1:0]         infl_cnt_q;

  logic [2:0]         credit;
  logic               req_fire, rsp_keep, rsp_drop, deq;
  logic               unused_lsbs;

  // Discarded (stale) responses still hold credit until they return.
  assign credit         = {1'b0, fifo_cnt_q} + {1'b0, infl_cnt_q} + {1'b0, disc_q};
  assign imem_req_valid = (state_q == RUN) && (credit < 3'd2) && !redirect_valid;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && (disc_q == 2'd0);
  assign rsp_drop       = imem_rsp_valid && (disc_q != 2'd0);

  assign ifu_valid = (fifo_cnt_q != 2'd0);
  assign ifu_instr = fifo_instr_q[fifo_rd_q];
  assign ifu_pc    = fifo_pc_q[fifo_rd_q];
  assign ifu_err   = fifo_err_q[fifo_rd_q];
  assign deq       = ifu_valid && ifu_ready;

  assign unused_lsbs = ^{pc_rtvec[1:0], redirect_pc[1:0]};

  always_comb begin
    pc_d   = pc_q;
    disc_d = disc_q;
    if (state_q == BOOT) begin
      pc_d = {pc_rtvec[PC_W-1:2], 2'b00};
    end else if (redirect_valid) begin
      pc_d   = {redirect_pc[PC_W-1:2], 2'b00};
      // A response landing this cycle retires its own request, so it is not stale.
      disc_d = infl_cnt_q + disc_q - {1'b0, imem_rsp_valid};
    end else begin
      if (req_fire) pc_d = pc_q + PC_W'(4);
      if (rsp_drop) disc_d = disc_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= '0;
      disc_q     <= '0;
      fifo_err_q <= '0;
      fifo_rd_q  <= 1'b0;
      fifo_wr_q  <= 1'b0;
      fifo_cnt_q <= '0;
      infl_rd_q  <= 1'b0;
      infl_wr_q  <= 1'b0;
      infl_cnt_q <= '0;
      for (int i = 0; i < 2; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
        infl_pc_q[i]    <= '0;
      end
    end else begin
      pc_q   <= pc_d;
      disc_q <= disc_d;
      case (state_q)
        BOOT: state_q <= RUN;
        RUN: begin
          if (redirect_valid) begin
            fifo_rd_q  <= 1'b0;
            fifo_wr_q  <= 1'b0;
            fifo_cnt_q <= '0;
            infl_rd_q  <= 1'b0;
            infl_wr_q  <= 1'b0;
            infl_cnt_q <= '0;
          end else begin
            if (req_fire) begin
              infl_pc_q[infl_wr_q] <= pc_q;
              infl_wr_q            <= ~infl_wr_q;
            end
            if (rsp_keep) begin
              fifo_instr_q[fifo_wr_q] <= imem_rsp_data;
              fifo_pc_q[fifo_wr_q]    <= infl_pc_q[infl_rd_q];
              fifo_err_q[fifo_wr_q]   <= imem_rsp_err;
              fifo_wr_q               <= ~fifo_wr_q;
              infl_rd_q               <= ~infl_rd_q;
            end
            if (deq) fifo_rd_q <= ~fifo_rd_q;
            fifo_cnt_q <= fifo_cnt_q + {1'b0, rsp_keep} - {1'b0, deq};
            infl_cnt_q <= infl_cnt_q + {1'b0, req_fire} - {1'b0, rsp_keep};
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;

  // A handshake coincident with a redirect still counts as delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   fetch_cnt_q <= '0;
    else if (deq) fetch_cnt_q <= fetch_cnt_q + 32'd1;
  end

  assign fetch_cnt = fetch_cnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter PC_W, 32, width of PC and fetch addresses; set from the codebase's PC_SIZE define.
REQ-002 Parameter INSTR_W, 32, instruction width.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port pc_rtvec  input  PC_W  reset vector; held stable while rst_n is low and for at least one cycle after release.
REQ-006 Port imem_req_valid  output  1  fetch request valid.
REQ-007 Port imem_req_ready  input  1  memory accepts the request.
REQ-008 Port imem_req_addr  output  PC_W  fetch address, word-aligned.
REQ-009 Port imem_rsp_valid  input  1  response valid; always accepted; at least 1 cycle after its request; in request order.
REQ-010 Port imem_rsp_data  input  INSTR_W  fetched instruction.
REQ-011 Port imem_rsp_err  input  1  bus error for this response.
REQ-012 Port ifu_valid  output  1  instruction available to decode.
REQ-013 Port ifu_ready  input  1  decode accepts.
REQ-014 Port ifu_instr  output  INSTR_W  instruction to decode.
REQ-015 Port ifu_pc  output  PC_W  address of ifu_instr.
REQ-016 Port ifu_err  output  1  fetch error flag for ifu_instr.
REQ-017 Port redirect_valid  input  1  branch/jump/trap redirect.
REQ-018 Port redirect_pc  input  PC_W  redirect target.

Function
REQ-019 States BOOT, RUN; BOOT -> RUN on first rising edge after rst_n release, loading pc <= {pc_rtvec[PC_W-1:2],2'b00}; no request issued in BOOT.
REQ-020 2-entry output FIFO of {instr, pc, err}; 2-entry in-flight queue of request PCs; credit = FIFO occupancy + outstanding requests, never above 2.
REQ-021 imem_req_valid = RUN & credit<2 & !redirect_valid; imem_req_addr = pc; on request handshake pc <= pc+4 (mod 2^PC_W, wrap silent), PC pushed to in-flight queue.
REQ-022 Accepted (non-discarded) response written to FIFO with PC popped from in-flight queue; ifu_valid asserts the cycle after the response.
REQ-023 ifu_valid = FIFO non-empty; outputs show FIFO head; pop on ifu_valid & ifu_ready; outputs stable while ifu_valid & !ifu_ready.
REQ-024 Simultaneous response and pop with FIFO full legal only via credit rule; push and pop same cycle keep occupancy unchanged.
REQ-025 redirect_valid cycle: FIFO and in-flight queue cleared at the edge; pc <= {redirect_pc[PC_W-1:2],2'b00}; discard counter <= outstanding count excluding a response arriving that same cycle; next request at redirect_pc the following cycle.
REQ-026 Discarded responses decrement the discard counter and free credit without entering the FIFO; new responses accepted only when counter is 0.
REQ-027 Redirect coincident with ifu_valid & ifu_ready: handshake counts as completed, then flush.
REQ-028 Redirect in BOOT ignored; back-to-back redirects: last one wins.
REQ-029 imem_rsp_err stored with entry; fetching continues sequentially afterwards.

Reset
REQ-030 rst_n low asynchronously: state BOOT, pc 0, FIFO and queues empty, discard counter 0, imem_req_valid 0, ifu_valid 0, ifu_instr 0, ifu_pc 0, ifu_err 0.
REQ-031 Reset mid-operation discards all state; responses to pre-reset requests are the memory's responsibility to drop.

Configuration
REQ-032 Macro IFU_PERF_CNT_EN defined: extra output fetch_cnt (32 bits) counting ifu_valid & ifu_ready handshakes, reset 0, wraps at 2^32, not cleared by redirect.
REQ-033 Macro undefined: port fetch_cnt and its counter absent; all other behaviour identical.

Verification
REQ-034 pc_rtvec=0x4, release rst_n, ready=1, 1-cycle memory -> addresses 0x4,0x8,0xC...; first ifu_valid with ifu_pc=0x4 three cycles after release.
REQ-035 ifu_ready=0 for 10 cycles -> at most 2 requests issued, FIFO holds 0x4 and 0x8, outputs stable; ifu_ready=1 -> both delivered in order.
REQ-036 redirect_valid with redirect_pc=0x103 while 2 requests outstanding -> next address 0x100, two stale responses dropped, first delivered ifu_pc=0x100.
REQ-037 imem_rsp_err=1 on address 0x8 -> ifu_err=1 only with ifu_pc=0x8; 0xC follows with ifu_err=0.
REQ-038 pc=0xFFFFFFFC fetched -> next address 0x0.
REQ-039 With IFU_PERF_CNT_EN, 5 accepted instructions -> fetch_cnt=5; rst_n pulse -> 0.
